// File: rtl/lfo_pkg.sv
// Shared types and constants for the chorus/flanger LFO (lfo_delay_mod).
// Also builds the quarter-wave sine table used when LFO_SINE_EN is defined.
package lfo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADVANCE = 3'd1,
    ST_SHAPE   = 3'd2,
    ST_MULT    = 3'd3,
    ST_DONE    = 3'd4
  } lfo_state_e;

  localparam int WAVE_WIDTH     = 15;
  localparam int MAG_MAX        = 32767;
  localparam int MULT_ITERS     = 14;
  localparam int ITER_W         = $clog2(MULT_ITERS);
  localparam int SINE_ROM_DEPTH = 256;
  localparam int ROM_ADDR_W     = $clog2(SINE_ROM_DEPTH);

  typedef logic [SINE_ROM_DEPTH-1:0][WAVE_WIDTH-1:0] sine_rom_t;

  // Entry i holds sin((i+0.5)/256 * pi/2) in Q15 using the odd cubic
  // x*(pi/2) - x^3*(pi/2-1), which hits exactly 0 and 1 at the ends.
  function automatic sine_rom_t build_sine_rom();
    sine_rom_t bits;
    longint    x;
    longint    v;
    bits = '0;
    for (int i = 0; i < SINE_ROM_DEPTH; i++) begin
      x = longint'(2 * i + 1);
      v = (x * 64'sd51472) / 64'sd512 - (x * x * x * 64'sd18704) / 64'sd134217728;
      if (v > longint'(MAG_MAX)) v = longint'(MAG_MAX);
      bits[ROM_ADDR_W'(i)] = WAVE_WIDTH'(v);
    end
    return bits;
  endfunction

endpackage

// File: rtl/lfo_delay_mod_sine_rom.sv
// lfo_sine_rom: synchronous 256x15 quarter-wave sine ROM, one-cycle read latency.
// Only instantiated by lfo_delay_mod when LFO_SINE_EN is defined.
module lfo_sine_rom
  import lfo_pkg::*;
(
  input  logic                  clk,
  input  logic [ROM_ADDR_W-1:0] addr_i,
  output logic [WAVE_WIDTH-1:0] data_o
);

  localparam sine_rom_t ROM = build_sine_rom();

  logic [WAVE_WIDTH-1:0] data_q;
  logic [WAVE_WIDTH-1:0] data_d;

  always_comb begin
    data_d = ROM[addr_i];
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/lfo_delay_mod.sv
// lfo_delay_mod: per-sample LFO (phase accumulator, shaper, shift-add depth
// multiplier) driving the delay buffer's extra-delay input. LFO_SINE_EN selects sine.
module lfo_delay_mod
  import lfo_pkg::*;
#(
  parameter int PHASE_WIDTH = 24,
  parameter int ADDR_WIDTH  = 14,
  parameter int MAX_DEPTH   = 800
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sampleTick_s_i,
  input  logic                   enable_i,
  input  logic [PHASE_WIDTH-1:0] rateInc_i,
  input  logic [ADDR_WIDTH-1:0]  depth_i,
  // LFOChanged_s_o is a one-cycle valid strobe with no ready: the value on
  // extraDelay_s_o is new in that cycle and held until the next strobe.
  output logic [ADDR_WIDTH-1:0]  extraDelay_s_o,
  output logic                   LFOChanged_s_o,
  output logic                   busy_c_o,
  output logic                   overrun_s_o,
  output lfo_state_e             state_dbg_o
);

  localparam int PROD_W = WAVE_WIDTH + ADDR_WIDTH;
  localparam int U_W    = WAVE_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_CLAMP = ADDR_WIDTH'(MAX_DEPTH);

  lfo_state_e             state_q, state_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic                   en_q, en_d;
  logic [ADDR_WIDTH-1:0]  depth_q, depth_d;
  logic [WAVE_WIDTH-1:0]  wave_q, wave_d;
  logic                   sign_q, sign_d;
  logic [ITER_W-1:0]      cnt_q, cnt_d;
  logic [PROD_W-1:0]      acc_q, acc_d;
  logic [ADDR_WIDTH-1:0]  extra_delay_q, extra_delay_d;
  logic                   strobe_q, strobe_d;
  logic                   overrun_q, overrun_d;

  logic [U_W-1:0]         u;
  logic [1:0]             quad;
  logic [WAVE_WIDTH-1:0]  frac;
  logic                   shape_ready;
  logic [WAVE_WIDTH-1:0]  shape_mag;
  logic [PROD_W-1:0]      addend;
  logic [ADDR_WIDTH-1:0]  mag;
  logic [ADDR_WIDTH-1:0]  depth_clamped;

  assign u    = phase_q[PHASE_WIDTH-1 -: U_W];
  assign quad = u[U_W-1 -: 2];
  assign frac = u[WAVE_WIDTH-1:0];

`ifdef LFO_SINE_EN
  logic                  rom_wait_q, rom_wait_d;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [WAVE_WIDTH-1:0] rom_data;

  // Odd quadrants mirror the quarter wave by reading the table backwards.
  assign rom_addr = quad[0] ? ~frac[WAVE_WIDTH-1 -: ROM_ADDR_W]
                            : frac[WAVE_WIDTH-1 -: ROM_ADDR_W];

  lfo_sine_rom u_sine_rom (
    .clk    (clk),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  assign rom_wait_d = (state_q == ST_SHAPE) && !rom_wait_q;

  always_ff @(posedge clk) begin
    if (!rst_n) rom_wait_q <= 1'b0;
    else        rom_wait_q <= rom_wait_d;
  end

  assign shape_ready = rom_wait_q;
  assign shape_mag   = rom_data;
`else
  assign shape_ready = 1'b1;
  assign shape_mag   = quad[0] ? (WAVE_WIDTH'(MAG_MAX) - frac) : frac;
`endif

  assign depth_clamped = (depth_i > DEPTH_CLAMP) ? DEPTH_CLAMP : depth_i;
  assign addend = depth_q[cnt_q] ? (PROD_W'(wave_q) << cnt_q) : '0;
  // Dropping the 15 fraction bits keeps |offset| strictly below the depth.
  assign mag    = acc_q[PROD_W-1 -: ADDR_WIDTH];

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    en_d          = en_q;
    depth_d       = depth_q;
    wave_d        = wave_q;
    sign_d        = sign_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    extra_delay_d = extra_delay_q;
    strobe_d      = 1'b0;
    overrun_d     = overrun_q | (sampleTick_s_i && (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (sampleTick_s_i) state_d = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        en_d    = enable_i;
        depth_d = depth_clamped;
        phase_d = enable_i ? (phase_q + rateInc_i) : '0;
        state_d = ST_SHAPE;
      end
      ST_SHAPE: begin
        if (shape_ready) begin
          wave_d  = en_q ? shape_mag : '0;
          sign_d  = quad[1];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_MULT;
        end
      end
      ST_MULT: begin
        acc_d = acc_q + addend;
        cnt_d = cnt_q + ITER_W'(1);
        if (cnt_q == ITER_W'(MULT_ITERS - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        extra_delay_d = sign_q ? (-mag) : mag;
        strobe_d      = 1'b1;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      en_q          <= 1'b0;
      depth_q       <= '0;
      wave_q        <= '0;
      sign_q        <= 1'b0;
      cnt_q         <= '0;
      acc_q         <= '0;
      extra_delay_q <= '0;
      strobe_q      <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      en_q          <= en_d;
      depth_q       <= depth_d;
      wave_q        <= wave_d;
      sign_q        <= sign_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      extra_delay_q <= extra_delay_d;
      strobe_q      <= strobe_d;
      overrun_q     <= overrun_d;
    end
  end

  assign extraDelay_s_o = extra_delay_q;
  assign LFOChanged_s_o = strobe_q;
  assign busy_c_o       = (state_q != ST_IDLE);
  assign overrun_s_o    = overrun_q;
  assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_lfo_delay_mod.sv
// Self-checking bench for lfo_delay_mod (triangle build): expected offsets are
// queued when a tick is driven and compared when the DUT raises its strobe.
module tb_lfo_delay_mod;
  import lfo_pkg::*;

  localparam int PW  = 24;
  localparam int AW  = 14;
  localparam int LAT = 17;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          tick   = 1'b0;
  logic          enable = 1'b0;
  logic [PW-1:0] rate   = '0;
  logic [AW-1:0] depth  = '0;
  logic [AW-1:0] extra_delay;
  logic          lfo_changed;
  logic          busy;
  logic          overrun;
  lfo_state_e    state_dbg;

  lfo_delay_mod #(
    .PHASE_WIDTH (PW),
    .ADDR_WIDTH  (AW),
    .MAX_DEPTH   (800)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sampleTick_s_i (tick),
    .enable_i       (enable),
    .rateInc_i      (rate),
    .depth_i        (depth),
    .extraDelay_s_o (extra_delay),
    .LFOChanged_s_o (lfo_changed),
    .busy_c_o       (busy),
    .overrun_s_o    (overrun),
    .state_dbg_o    (state_dbg)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            n_checks   = 0;
  int            n_pass     = 0;
  int            strobe_cnt = 0;
  logic [AW-1:0] exp_q[$];
  int            tick_q[$];
  logic [PW-1:0] model_phase = '0;
  logic          prev_strobe = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // driver: one tick; accepted ticks advance the model and queue a result
  task automatic send_tick(input bit accepted, input bit use_const, input int const_val);
    logic [16:0]  u;
    logic [14:0]  f;
    logic [14:0]  m;
    int           dc;
    int           mg;
    int           v;
    if (accepted) begin
      model_phase = enable ? (model_phase + rate) : '0;
      u  = model_phase[PW-1 -: 17];
      f  = u[14:0];
      m  = !enable ? 15'd0 : (u[15] ? (15'd32767 - f) : f);
      dc = (int'(depth) > 800) ? 800 : int'(depth);
      mg = (int'(m) * dc) / 32768;
      v  = u[16] ? -mg : mg;
      exp_q.push_back(AW'(use_const ? const_val : v));
    end
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    if (accepted) begin
      tick_q.push_back(cyc);
      check("busy_after_tick", int'(busy), 1);
      check("state_after_tick", int'(state_dbg), int'(ST_ADVANCE));
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_delay"}, int'(extra_delay), 0);
    check({tag, "_strobe"}, int'(lfo_changed), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_state"}, int'(state_dbg), int'(ST_IDLE));
  endtask

  // scoreboard
  always @(negedge clk) begin
    logic [AW-1:0] e;
    int            t;
    if (rst_n && lfo_changed) begin
      strobe_cnt <= strobe_cnt + 1;
      if (exp_q.size() == 0) begin
        check("spurious_strobe", 1, 0);
      end else begin
        e = exp_q.pop_front();
        t = tick_q.pop_front();
        check("value", int'($signed(extra_delay)), int'($signed(e)));
        check("latency", cyc - t, LAT);
      end
      check("strobe_one_cycle", int'(prev_strobe), 0);
    end
    prev_strobe <= rst_n & lfo_changed;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int sweep[5];
    int cnt_before;
    sweep = '{799, 0, -799, 0, 799};

    // reset held for 3 cycles
    rst_n = 1'b0;
    idle(3);
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    idle(1);
    check_reset_outputs("reset_released");

    // triangle sweep, ticks 100 cycles apart
    enable = 1'b1;
    rate   = PW'(1 << 22);
    depth  = AW'(800);
    for (int k = 0; k < 5; k++) begin
      send_tick(1'b1, 1'b1, sweep[k]);
      idle(98);
    end
    wait_drain(50);

    // disabled tick still strobes, then resumes from phase 0
    enable = 1'b0;
    send_tick(1'b1, 1'b1, 0);
    idle(20);
    enable = 1'b1;
    send_tick(1'b1, 1'b1, 799);
    idle(20);
    wait_drain(20);

    // depth clamp from a known phase of 0
    enable = 1'b0;
    send_tick(1'b1, 1'b1, 0);
    idle(20);
    enable = 1'b1;
    depth  = AW'(2000);
    send_tick(1'b1, 1'b1, 799);
    idle(20);
    wait_drain(20);

    // overrun: second tick 5 cycles after the first is dropped
    check("overrun_before", int'(overrun), 0);
    depth      = AW'(800);
    cnt_before = strobe_cnt;
    send_tick(1'b1, 1'b0, 0);
    idle(3);
    send_tick(1'b0, 1'b0, 0);
    idle(20);
    wait_drain(20);
    check("overrun_set", int'(overrun), 1);
    check("overrun_one_strobe", strobe_cnt - cnt_before, 1);
    send_tick(1'b1, 1'b0, 0);
    idle(20);
    wait_drain(20);
    check("overrun_sticky", int'(overrun), 1);

    // abort: reset 8 cycles after a tick
    cnt_before = strobe_cnt;
    send_tick(1'b0, 1'b0, 0);
    idle(6);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    model_phase = '0;
    idle(1);
    check_reset_outputs("abort");
    idle(30);
    check("abort_no_strobe", strobe_cnt - cnt_before, 0);
    rate  = PW'(1 << 22);
    depth = AW'(800);
    send_tick(1'b1, 1'b1, 799);
    idle(20);
    wait_drain(20);

    // random ticks; inputs scrambled mid-computation must not matter
    for (int k = 0; k < 12; k++) begin
      enable = ($urandom_range(0, 4) != 0);
      rate   = PW'($urandom);
      depth  = AW'($urandom_range(0, 2500));
      send_tick(1'b1, 1'b0, 0);
      rate   = PW'($urandom);
      depth  = AW'($urandom);
      enable = 1'(($urandom_range(0, 1)));
      idle($urandom_range(16, 30));
    end
    wait_drain(60);
    idle(2);
    check("final_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
